factorial_inverse: RTL and testbench



---
 rtl/factorial_inverse.sv | 178 +++++++++++++++++
 tb/tb_factorial_inverse.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/factorial_inverse.sv
// Inverse factorial: finds the largest n with n! <= value and flags an exact match.
// Go/done engine with control unit and datapath split inside one top.
module factorial_inverse_cu (
    input  logic       clk,
    input  logic       rst,
    input  logic       go_i,
    input  logic       eq_i,
    input  logic       gt_i,
    input  logic       ovf_i,
    output logic       init_en_o,
    output logic       check_en_o,
    output logic       mult_en_o,
    output logic [2:0] state_o,
    output logic       busy_o,
    output logic       done_o
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        CHECK = 3'd2,
        MULT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   busy_q;
    logic   done_q;

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = go_i ? INIT : IDLE;
            INIT:    state_d = CHECK;
            CHECK:   state_d = (eq_i || gt_i) ? DONE : MULT;
            MULT:    state_d = ovf_i ? DONE : CHECK;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // busy/done are registered alongside the state so they change on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == INIT) || (state_d == CHECK) || (state_d == MULT);
            done_q  <= (state_d == DONE);
        end
    end

    assign init_en_o  = (state_q == INIT);
    assign check_en_o = (state_q == CHECK);
    assign mult_en_o  = (state_q == MULT);
    assign state_o    = state_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
endmodule

module factorial_inverse_dp #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init_en_i,
    input  logic            check_en_i,
    input  logic            mult_en_i,
    input  logic [SIZE-1:0] value_i,
    output logic            eq_o,
    output logic            gt_o,
    output logic            ovf_o,
    output logic [SIZE-1:0] n_o,
    output logic            exact_o
);
    logic [SIZE-1:0]   val_q;
    logic [SIZE-1:0]   prod_q;
    logic [SIZE-1:0]   k_q;
    logic [SIZE-1:0]   n_q;
    logic              exact_q;
    logic [SIZE-1:0]   k_inc;
    logic [2*SIZE-1:0] p;

    assign k_inc = k_q + SIZE'(1);
    // Full-width product: any upper bit set means (k+1)! no longer fits, which ends the search.
    assign p     = {{SIZE{1'b0}}, prod_q} * {{SIZE{1'b0}}, k_inc};
    assign ovf_o = |p[2*SIZE-1:SIZE];
    assign eq_o  = (prod_q == val_q);
    assign gt_o  = (prod_q > val_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q   <= '0;
            prod_q  <= SIZE'(1);
            k_q     <= SIZE'(1);
            n_q     <= '0;
            exact_q <= 1'b0;
        end else begin
            if (init_en_i) begin
                val_q  <= value_i;
                prod_q <= SIZE'(1);
                k_q    <= SIZE'(1);
            end
            if (check_en_i) begin
                if (eq_o) begin
                    n_q     <= k_q;
                    exact_q <= 1'b1;
                end else if (gt_o) begin
                    n_q     <= k_q - SIZE'(1);
                    exact_q <= 1'b0;
                end
            end
            if (mult_en_i) begin
                if (ovf_o) begin
                    n_q     <= k_q;
                    exact_q <= 1'b0;
                end else begin
                    prod_q <= p[SIZE-1:0];
                    k_q    <= k_inc;
                end
            end
        end
    end

    assign n_o     = n_q;
    assign exact_o = exact_q;
endmodule

module factorial_inverse #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            go,
    input  logic [SIZE-1:0] value,
    output logic [2:0]      curr_state,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] n,
    output logic            exact
);
    logic init_en;
    logic check_en;
    logic mult_en;
    logic eq;
    logic gt;
    logic ovf;

    factorial_inverse_cu u_cu (
        .clk        (clk),
        .rst        (rst),
        .go_i       (go),
        .eq_i       (eq),
        .gt_i       (gt),
        .ovf_i      (ovf),
        .init_en_o  (init_en),
        .check_en_o (check_en),
        .mult_en_o  (mult_en),
        .state_o    (curr_state),
        .busy_o     (busy),
        .done_o     (done)
    );

    factorial_inverse_dp #(.SIZE(SIZE)) u_dp (
        .clk        (clk),
        .rst        (rst),
        .init_en_i  (init_en),
        .check_en_i (check_en),
        .mult_en_i  (mult_en),
        .value_i    (value),
        .eq_o       (eq),
        .gt_o       (gt),
        .ovf_o      (ovf),
        .n_o        (n),
        .exact_o    (exact)
    );
endmodule

// File: tb/tb_factorial_inverse.sv
// Directed bench for factorial_inverse with a scoreboard of expected results.
module tb_factorial_inverse;
    localparam int SIZE = 8;

    logic            clk;
    logic            rst;
    logic            go;
    logic [SIZE-1:0] value;
    logic [2:0]      curr_state;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] n;
    logic            exact;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [SIZE-1:0] n;
        logic            exact;
        int              lat;
    } exp_t;
    exp_t sb[$];

    factorial_inverse #(.SIZE(SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .value      (value),
        .curr_state (curr_state),
        .busy       (busy),
        .done       (done),
        .n          (n),
        .exact      (exact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [SIZE-1:0] en, input logic ee, input int lat);
        exp_t e;
        e.n = en;
        e.exact = ee;
        e.lat = lat;
        sb.push_back(e);
    endtask

    // c0 = edges already counted since the go sample edge (that edge counts as 1).
    task automatic wait_result(input string tag, input int c0);
        int c;
        exp_t e;
        c = c0;
        while (done !== 1'b1 && c < 60) begin
            @(posedge clk);
            c++;
            #1;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_n"}, 32'(n), 32'(e.n));
            check({tag, "_exact"}, 32'(exact), 32'(e.exact));
            check({tag, "_latency"}, 32'(c), 32'(e.lat));
            check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    task automatic run_one(input string tag, input logic [SIZE-1:0] v,
                           input logic [SIZE-1:0] en, input logic ee, input int lat);
        logic [SIZE-1:0] prev_n;
        logic            prev_e;
        @(negedge clk);
        value = v;
        go = 1'b1;
        push_exp(en, ee, lat);
        prev_n = n;
        prev_e = exact;
        @(posedge clk);
        #1;
        go = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_hold_n"}, 32'(n), 32'(prev_n));
        check({tag, "_hold_exact"}, 32'(exact), 32'(prev_e));
        wait_result(tag, 2);
    endtask

    initial begin
        int c;
        int done_cnt;
        rst = 1'b0;
        go = 1'b0;
        value = '0;

        #3 rst = 1'b1;
        #1;
        check("rst_state", 32'(curr_state), 32'd0);
        check("rst_n", 32'(n), 32'd0);
        check("rst_exact", 32'(exact), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_idle", 32'(curr_state), 32'd0);

        run_one("v120", 8'd120, 8'd5, 1'b1, 11);
        run_one("v100", 8'd100, 8'd4, 1'b0, 11);
        run_one("v2",   8'd2,   8'd2, 1'b1, 5);
        run_one("v0",   8'd0,   8'd0, 1'b0, 3);
        run_one("v1",   8'd1,   8'd1, 1'b1, 3);
        run_one("v255", 8'd255, 8'd5, 1'b0, 12);

        // go held high: value changes after capture, then a second run starts on its own.
        @(negedge clk);
        value = 8'd24;
        go = 1'b1;
        push_exp(8'd4, 1'b1, 9);
        push_exp(8'd3, 1'b1, 7);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        value = 8'd6;
        wait_result("dist24", 2);
        check("dist_idle_after_done", 32'(curr_state), 32'd0);
        @(posedge clk);
        #1;
        go = 1'b0;
        check("dist_second_init", 32'(curr_state), 32'd1);
        wait_result("dist6", 1);

        // Asynchronous reset while in MULT.
        @(negedge clk);
        value = 8'd120;
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        c = 0;
        while (curr_state !== 3'd3 && c < 20) begin
            @(posedge clk);
            c++;
            #1;
        end
        check("midrst_reach_mult", 32'(curr_state), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("midrst_state", 32'(curr_state), 32'd0);
        check("midrst_n", 32'(n), 32'd0);
        check("midrst_exact", 32'(exact), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_cnt++;
        end
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        check("midrst_stays_idle", 32'(curr_state), 32'd0);

        run_one("after_rst_v6", 8'd6, 8'd3, 1'b1, 7);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
